// File: rtl/obuf_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obuf_streamer: drains the OBUF circular buffer onto a valid/ready stream  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module obuf_streamer #(
  parameter int unsigned OBUF    = 'h1400,
  parameter int unsigned OBUF_SZ = 'h400,
  parameter int          ASZ     = 17,
  parameter int          PSZ     = $clog2(OBUF_SZ)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [PSZ-1:0] wp,
  output logic           mem_req,
  output logic [ASZ-1:0] mem_addr,
  input  logic           mem_gnt,
  input  logic [7:0]     mem_vo,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [PSZ-1:0] rp,
  output logic           empty,
  output logic           busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [PSZ-1:0] rp_q, rp_d;
  logic [PSZ-1:0] rp_inc;
  logic [7:0]     tx_data_q, tx_data_d;

  // PSZ-bit arithmetic gives the modulo-OBUF_SZ wrap for free.
  assign rp_inc = rp_q + PSZ'(1);

  assign empty    = (rp_q == wp);
  assign rp       = rp_q;
  assign tx_data  = tx_data_q;
  assign mem_addr = ASZ'(OBUF) + ASZ'(rp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rp_q      <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rp_q      <= rp_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rp_d      = rp_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (en && !empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid in the cycle following the grant.
        tx_data_d = mem_vo;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          rp_d    = rp_inc;
          state_d = (en && (rp_inc != wp)) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == S_REQ);
    tx_valid = (state_q == S_SEND);
    busy     = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_obuf_streamer.sv
`default_nettype none
// Bench for obuf_streamer: directed steps plus a randomized drain phase,
// checked against a byte-stream model of the circular buffer.
module tb_obuf_streamer;

  localparam int unsigned OBUF = 'h1400;
  localparam int unsigned SZ   = 'h400;

  logic        clk = 1'b0;
  logic        rst, en, mem_gnt, tx_ready;
  logic [9:0]  wp, rp;
  logic        mem_req, tx_valid, empty, busy;
  logic [16:0] mem_addr;
  logic [7:0]  mem_vo, tx_data;

  obuf_streamer dut (
    .clk(clk), .rst(rst), .en(en), .wp(wp),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_vo(mem_vo),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rp(rp), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  tbmem [SZ];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          hs_cyc [$];
  logic [16:0] addr_log [$];
  logic [9:0]  model_rp = '0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;
  logic [7:0]  prev_data = '0;

  wire [16:0] mem_off = mem_addr - 17'(OBUF);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: data appears the cycle after a granted request, garbage otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_gnt && mem_addr >= 17'(OBUF) && mem_off < 17'(SZ))
      mem_vo <= tbmem[mem_off[9:0]];
    else
      mem_vo <= 8'($urandom);
  end

  // Stream monitor: in-order bytes from the buffer, plus hold-while-stalled rules.
  always @(negedge clk) begin
    logic hs;
    if (!prev_rst && prev_valid && !prev_hs) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_data", 32'(tx_data), 32'(prev_data));
    end
    hs = tx_valid && tx_ready && !rst;
    if (hs) begin
      chk("stream_byte", 32'(tx_data), 32'(tbmem[model_rp]));
      model_rp = model_rp + 10'd1;
      hs_cnt++;
      hs_cyc.push_back(cyc);
    end
    if (mem_req && mem_gnt && !rst) addr_log.push_back(mem_addr);
    prev_valid = tx_valid;
    prev_hs    = hs;
    prev_rst   = rst;
    prev_data  = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wp = '0;
    model_rp = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int maxc, input bit rnd);
    int n = 0;
    while (!(rp == wp && !busy) && n < maxc) begin
      if (rnd) begin
        mem_gnt  = 1'($urandom_range(0, 1));
        tx_ready = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    mem_gnt  = 1'b1;
    tx_ready = 1'b1;
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0, nw;
    rst = 1'b1; en = 1'b0; wp = '0; mem_gnt = 1'b1; tx_ready = 1'b1;
    for (int i = 0; i < int'(SZ); i++) tbmem[i] = 8'($urandom);

    // Reset state
    tick();
    tick();
    chk("rst_rp", 32'(rp), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'h1400);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    tick();

    // Single byte latency
    tbmem[0] = 8'h41;
    en = 1'b1;
    tick();
    wp = 10'd1;
    tick();
    chk("lat_req", 32'(mem_req), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'h1400);
    chk("lat_busy", 32'(busy), 32'd1);
    tick();
    chk("lat_wait_req", 32'(mem_req), 32'd0);
    chk("lat_wait_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(tx_valid), 32'd1);
    chk("lat_data", 32'(tx_data), 32'h41);
    tick();
    chk("single_valid_drop", 32'(tx_valid), 32'd0);
    chk("single_rp", 32'(rp), 32'd1);
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_count", 32'(hs_cnt), 32'd1);

    // Burst "ok\n"
    do_reset();
    tbmem[0] = 8'h6f; tbmem[1] = 8'h6b; tbmem[2] = 8'h0a;
    hs_cyc.delete();
    wp = 10'd3;
    drain("burst_timeout", 40, 1'b0);
    chk("burst_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      chk("burst_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      chk("burst_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end
    chk("burst_rp", 32'(rp), 32'd3);

    // Back-pressure
    tbmem[3] = 8'($urandom);
    tx_ready = 1'b0;
    n0 = hs_cnt;
    wp = 10'd4;
    n = 0;
    while (!tx_valid && n < 10) begin tick(); n++; end
    chk("bp_valid_seen", 32'(tx_valid), 32'd1);
    repeat (10) begin
      tick();
      chk("bp_valid", 32'(tx_valid), 32'd1);
      chk("bp_data", 32'(tx_data), 32'(tbmem[3]));
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_drop", 32'(tx_valid), 32'd0);
    chk("bp_rp", 32'(rp), 32'd4);
    chk("bp_once", 32'(hs_cnt - n0), 32'd1);

    // Arbitration stall
    mem_gnt = 1'b0;
    tbmem[4] = 8'($urandom);
    wp = 10'd5;
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    repeat (5) begin
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'h1404);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    chk("stall_granted", 32'(mem_req), 32'd0);
    drain("stall_timeout", 20, 1'b0);
    chk("stall_rp", 32'(rp), 32'd5);

    // Randomized drain up to 'h3fe
    while (wp != 10'h3fe) begin
      nw = int'(wp) + int'($urandom_range(1, 40));
      if (nw > 'h3fe) nw = 'h3fe;
      wp = 10'(nw);
      drain("rand_timeout", 1200, 1'b1);
      chk("rand_rp", 32'(rp), 32'(wp));
    end

    // Wrap-around
    tbmem[10'h3fe] = 8'h31; tbmem[10'h3ff] = 8'h32; tbmem[0] = 8'h33;
    addr_log.delete();
    wp = 10'd1;
    drain("wrap_timeout", 60, 1'b0);
    chk("wrap_nreads", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3) begin
      chk("wrap_addr0", 32'(addr_log[0]), 32'h17fe);
      chk("wrap_addr1", 32'(addr_log[1]), 32'h17ff);
      chk("wrap_addr2", 32'(addr_log[2]), 32'h1400);
    end
    chk("wrap_rp", 32'(rp), 32'd1);

    // Reset during WAIT
    tbmem[1] = 8'($urandom);
    wp = 10'd2;
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    tick();
    n0 = hs_cnt;
    rst = 1'b1; wp = '0; model_rp = '0;
    tick();
    chk("rstw_valid", 32'(tx_valid), 32'd0);
    chk("rstw_req", 32'(mem_req), 32'd0);
    chk("rstw_rp", 32'(rp), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("rstw_nobyte", 32'(hs_cnt - n0), 32'd0);

    // Reset during SEND
    tbmem[0] = 8'($urandom);
    tx_ready = 1'b0;
    wp = 10'd1;
    n = 0;
    while (!tx_valid && n < 10) begin tick(); n++; end
    n0 = hs_cnt;
    rst = 1'b1; wp = '0; model_rp = '0;
    tick();
    chk("rsts_valid", 32'(tx_valid), 32'd0);
    chk("rsts_req", 32'(mem_req), 32'd0);
    chk("rsts_rp", 32'(rp), 32'd0);
    chk("rsts_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (4) tick();
    chk("rsts_nobyte", 32'(hs_cnt - n0), 32'd0);

    // Enable off, then on
    en = 1'b0;
    for (int i = 0; i < 8; i++) tbmem[i] = 8'($urandom);
    wp = 10'd5;
    n = 0;
    repeat (10) begin
      tick();
      if (mem_req || busy) n++;
    end
    chk("en_off_idle", 32'(n), 32'd0);
    n0 = hs_cnt;
    en = 1'b1;
    drain("en_on_timeout", 60, 1'b0);
    chk("en_on_count", 32'(hs_cnt - n0), 32'd5);
    chk("en_on_rp", 32'(rp), 32'd5);

    // Enable dropped mid-transfer: current byte completes, then park
    wp = 10'd8;
    n = 0;
    while (!mem_req && n < 10) begin tick(); n++; end
    n0 = hs_cnt;
    en = 1'b0;
    repeat (20) tick();
    chk("en_mid_count", 32'(hs_cnt - n0), 32'd1);
    chk("en_mid_rp", 32'(rp), 32'd6);
    chk("en_mid_idle", 32'(busy), 32'd0);
    en = 1'b1;
    drain("en_resume_timeout", 40, 1'b0);
    chk("en_resume_rp", 32'(rp), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
